// File: rtl/mcp3008_responder.sv
// MCP3008-style SPI ADC responder.
// Resynchronises the initiator's dclk/cs_n/din into the clk domain and
// answers each conversion request with a 10-bit channel code. The code goes
// out MSB first and then LSB first. Single-ended or differential codes are
// taken from the ch_data bus.
module mcp3008_responder #(
   parameter int SYNC_STAGES = 2
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        dclk,
   input  logic        cs_n,
   input  logic        din,
   output logic        dout,
   output logic        dout_oe,
   input  logic [79:0] ch_data,
   output logic        frame_done,
   output logic        frame_sgl,
   output logic [2:0]  frame_ch,
   output logic [9:0]  frame_code,
   output logic [7:0]  abort_cnt
);

   localparam int S = SYNC_STAGES;

   typedef enum logic [2:0] {
      IDLE,
      START,
      CFG,
      NULL,
      MSB,
      LSB,
      ZERO
   } state_t;

   // ------------------------------------------------------------------
   // Input synchronisers and edge detection
   // ------------------------------------------------------------------
   logic [S-1:0] dclk_sync_reg;
   logic [S-1:0] cs_sync_reg;
   logic [S-1:0] din_sync_reg;
   logic [S-1:0] flush_reg;
   logic         dclk_prev_reg;
   logic         cs_prev_reg;

   logic dclk_s;
   logic cs_s;
   logic din_s;
   logic flushed;
   logic dclk_rise;
   logic dclk_fall;
   logic cs_rise;
   logic cs_fall;

   // Shift the asynchronous pins through the synchroniser chains. The flush
   // chain marks when the chain outputs reflect real pin samples again after
   // a reset.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         dclk_sync_reg <= '0;
         cs_sync_reg   <= '1;
         din_sync_reg  <= '0;
         flush_reg     <= '0;
         dclk_prev_reg <= 1'b0;
         cs_prev_reg   <= 1'b1;
      end else begin
         dclk_sync_reg <= {dclk_sync_reg[S-2:0], dclk};
         cs_sync_reg   <= {cs_sync_reg[S-2:0], cs_n};
         din_sync_reg  <= {din_sync_reg[S-2:0], din};
         flush_reg     <= {flush_reg[S-2:0], 1'b1};
         dclk_prev_reg <= dclk_sync_reg[S-1];
         cs_prev_reg   <= cs_sync_reg[S-1];
      end
   end

   assign dclk_s    = dclk_sync_reg[S-1];
   assign cs_s      = cs_sync_reg[S-1];
   assign din_s     = din_sync_reg[S-1];
   assign flushed   = flush_reg[S-1];
   assign dclk_rise = dclk_s & ~dclk_prev_reg;
   assign dclk_fall = ~dclk_s & dclk_prev_reg;
   assign cs_rise   = cs_s & ~cs_prev_reg;
   assign cs_fall   = ~cs_s & cs_prev_reg;

   // ------------------------------------------------------------------
   // Channel selection and code computation
   // ------------------------------------------------------------------
   logic [9:0]  ch_arr [8];
   logic [3:0]  cfg_reg;
   logic [3:0]  cfg_next;
   logic [2:0]  sel_p;
   logic [2:0]  sel_n;
   logic [9:0]  in_p;
   logic [9:0]  in_n;
   logic [10:0] diff;
   logic [9:0]  code_calc;

   generate
      for (genvar gi = 0; gi < 8; gi++) begin : g_ch
         assign ch_arr[gi] = ch_data[10*gi +: 10];
      end
   endgenerate

   // cfg_reg holds {SGL, D2, D1, D0}; the differential partner differs in D0
   assign sel_p = cfg_reg[2:0];
   assign sel_n = {cfg_reg[2:1], ~cfg_reg[0]};
   assign in_p  = ch_arr[sel_p];
   assign in_n  = ch_arr[sel_n];
   assign diff  = {1'b0, in_p} - {1'b0, in_n};

   // Single-ended passes the channel through. Differential clips at zero
   // and clamps the 11-bit difference to 10 bits.
   always_comb begin
      code_calc = 10'd0;
      if (cfg_reg[3]) begin
         code_calc = in_p;
      end else if (in_p >= in_n) begin
         code_calc = diff[10] ? 10'h3FF : diff[9:0];
      end
   end

   // ------------------------------------------------------------------
   // Frame state machine
   // ------------------------------------------------------------------
   state_t      state_reg,      state_next;
   logic [3:0]  bit_cnt_reg,    bit_cnt_next;
   logic [9:0]  code_reg,       code_next;
   logic        latch_reg,      latch_next;
   logic        armed_reg,      armed_next;
   logic        dout_reg,       dout_next;
   logic        dout_oe_reg,    dout_oe_next;
   logic        frame_done_reg, frame_done_next;
   logic        frame_sgl_reg,  frame_sgl_next;
   logic [2:0]  frame_ch_reg,   frame_ch_next;
   logic [9:0]  frame_code_reg, frame_code_next;
   logic [7:0]  abort_cnt_reg,  abort_cnt_next;

   // State and datapath register update
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_reg      <= IDLE;
         bit_cnt_reg    <= 4'd0;
         cfg_reg        <= 4'd0;
         code_reg       <= 10'd0;
         latch_reg      <= 1'b0;
         armed_reg      <= 1'b0;
         dout_reg       <= 1'b0;
         dout_oe_reg    <= 1'b0;
         frame_done_reg <= 1'b0;
         frame_sgl_reg  <= 1'b0;
         frame_ch_reg   <= 3'd0;
         frame_code_reg <= 10'd0;
         abort_cnt_reg  <= 8'd0;
      end else begin
         state_reg      <= state_next;
         bit_cnt_reg    <= bit_cnt_next;
         cfg_reg        <= cfg_next;
         code_reg       <= code_next;
         latch_reg      <= latch_next;
         armed_reg      <= armed_next;
         dout_reg       <= dout_next;
         dout_oe_reg    <= dout_oe_next;
         frame_done_reg <= frame_done_next;
         frame_sgl_reg  <= frame_sgl_next;
         frame_ch_reg   <= frame_ch_next;
         frame_code_reg <= frame_code_next;
         abort_cnt_reg  <= abort_cnt_next;
      end
   end

   // Next-state logic. A cs_n rise beats any dclk edge in the same cycle.
   always_comb begin
      state_next      = state_reg;
      bit_cnt_next    = bit_cnt_reg;
      cfg_next        = cfg_reg;
      code_next       = code_reg;
      latch_next      = 1'b0;
      armed_next      = armed_reg;
      dout_next       = dout_reg;
      dout_oe_next    = dout_oe_reg;
      frame_done_next = 1'b0;
      frame_sgl_next  = frame_sgl_reg;
      frame_ch_next   = frame_ch_reg;
      frame_code_next = frame_code_reg;
      abort_cnt_next  = abort_cnt_reg;

      // Only a cs_n that has really been seen high may start a frame. This
      // keeps a reset under a low cs_n from starting a bogus frame.
      if (flushed && cs_s) begin
         armed_next = 1'b1;
      end

      // Capture the code one clk after D0; later ch_data changes are ignored
      if (latch_reg) begin
         code_next = code_calc;
      end

      if (state_reg != IDLE && cs_rise) begin
         state_next   = IDLE;
         bit_cnt_next = 4'd0;
         dout_next    = 1'b0;
         dout_oe_next = 1'b0;
         if (state_reg == LSB || state_reg == ZERO) begin
            frame_done_next = 1'b1;
            frame_sgl_next  = cfg_reg[3];
            frame_ch_next   = cfg_reg[2:0];
            frame_code_next = code_reg;
         end else if (abort_cnt_reg != 8'hFF) begin
            abort_cnt_next = abort_cnt_reg + 8'd1;
         end
      end else begin
         case (state_reg)
            IDLE: begin
               dout_next    = 1'b0;
               dout_oe_next = 1'b0;
               if (armed_reg && cs_fall) begin
                  state_next   = START;
                  dout_oe_next = 1'b1;
               end
            end
            START: begin
               if (dclk_rise && din_s) begin
                  state_next   = CFG;
                  bit_cnt_next = 4'd0;
               end
            end
            CFG: begin
               if (dclk_rise) begin
                  cfg_next = {cfg_reg[2:0], din_s};
                  if (bit_cnt_reg == 4'd3) begin
                     state_next   = NULL;
                     bit_cnt_next = 4'd0;
                     latch_next   = 1'b1;
                  end else begin
                     bit_cnt_next = bit_cnt_reg + 4'd1;
                  end
               end
            end
            NULL: begin
               if (dclk_fall) begin
                  dout_next    = 1'b0;
                  state_next   = MSB;
                  bit_cnt_next = 4'd9;
               end
            end
            MSB: begin
               if (dclk_fall) begin
                  dout_next = code_reg[bit_cnt_reg];
                  if (bit_cnt_reg == 4'd0) begin
                     state_next   = LSB;
                     bit_cnt_next = 4'd1;
                  end else begin
                     bit_cnt_next = bit_cnt_reg - 4'd1;
                  end
               end
            end
            LSB: begin
               if (dclk_fall) begin
                  dout_next = code_reg[bit_cnt_reg];
                  if (bit_cnt_reg == 4'd9) begin
                     state_next = ZERO;
                  end else begin
                     bit_cnt_next = bit_cnt_reg + 4'd1;
                  end
               end
            end
            ZERO: begin
               if (dclk_fall) begin
                  dout_next = 1'b0;
               end
            end
            default: begin
               state_next   = IDLE;
               dout_next    = 1'b0;
               dout_oe_next = 1'b0;
            end
         endcase
      end
   end

   assign dout       = dout_reg;
   assign dout_oe    = dout_oe_reg;
   assign frame_done = frame_done_reg;
   assign frame_sgl  = frame_sgl_reg;
   assign frame_ch   = frame_ch_reg;
   assign frame_code = frame_code_reg;
   assign abort_cnt  = abort_cnt_reg;

endmodule

// File: tb/tb_mcp3008_responder.sv
// Self-checking bench for mcp3008_responder: an SPI initiator model drives
// frames and checks received bits and frame results against a reference model.
module tb_mcp3008_responder;

   localparam int SYNC = 2;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        dclk;
   logic        cs_n;
   logic        din;
   logic        dout;
   logic        dout_oe;
   logic [79:0] ch_data;
   logic        frame_done;
   logic        frame_sgl;
   logic [2:0]  frame_ch;
   logic [9:0]  frame_code;
   logic [7:0]  abort_cnt;

   mcp3008_responder #(.SYNC_STAGES(SYNC)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .dclk       (dclk),
      .cs_n       (cs_n),
      .din        (din),
      .dout       (dout),
      .dout_oe    (dout_oe),
      .ch_data    (ch_data),
      .frame_done (frame_done),
      .frame_sgl  (frame_sgl),
      .frame_ch   (frame_ch),
      .frame_code (frame_code),
      .abort_cnt  (abort_cnt)
   );

   always #5 clk = ~clk;

   int tests_run    = 0;
   int tests_failed = 0;
   int done_cnt     = 0;

   // reference state
   int ch_m [8];
   int half_per;
   int exp_abort;
   int last_sgl;
   int last_ch;
   int last_code;

   // count frame_done pulses
   always @(negedge clk) begin
      if (frame_done === 1'b1) done_cnt++;
   end

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests_run++;
      if (obs !== exp) begin
         tests_failed++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic wait_clk(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic apply_ch();
      for (int i = 0; i < 8; i++) ch_data[10*i +: 10] = ch_m[i][9:0];
   endtask

   task automatic scramble_ch();
      for (int i = 0; i < 8; i++) ch_m[i] = $urandom_range(0, 1023);
      apply_ch();
   endtask

   // ADC behaviour: single-ended returns the channel; differential returns
   // the non-negative difference against the channel with D0 flipped.
   function automatic int model_code(input int sgl, input int ch);
      int p;
      int n;
      if (sgl != 0) return ch_m[ch];
      p = ch_m[ch];
      n = ch_m[ch ^ 1];
      return (p >= n) ? (p - n) : 0;
   endfunction

   // one dclk period: din set while low, dout sampled at the rising edge
   task automatic dclk_cycle(input logic d, output logic q);
      din = d;
      wait_clk(half_per);
      dclk = 1'b1;
      q = dout;
      wait_clk(half_per);
      dclk = 1'b0;
   endtask

   // One chip-select transaction. ncfg of the z+5 config bits are sent;
   // with the full config, r response clocks follow.
   task automatic run_frame(input int z, input int sgl, input int ch, input int ncfg,
                            input int r, input bit scramble);
      int   code;
      int   exp_bits[$];
      int   cfg_bits[$];
      int   total;
      bit   full;
      bit   done_exp;
      int   done0;
      logic q;
      int   expb;

      code  = model_code(sgl, ch);
      total = z + 5;
      full  = (ncfg >= total);
      done_exp = full && (r >= 10);
      done0 = done_cnt;

      // expected response: null, MSB-first B9..B0, LSB-first B1..B9, zeros
      exp_bits.push_back(0);
      for (int b = 9; b >= 0; b--) exp_bits.push_back((code >> b) & 1);
      for (int b = 1; b <= 9; b++) exp_bits.push_back((code >> b) & 1);

      for (int i = 0; i < z; i++) cfg_bits.push_back(0);
      cfg_bits.push_back(1);
      cfg_bits.push_back(sgl);
      cfg_bits.push_back((ch >> 2) & 1);
      cfg_bits.push_back((ch >> 1) & 1);
      cfg_bits.push_back(ch & 1);

      cs_n = 1'b0;
      wait_clk(half_per);
      for (int i = 0; i < ncfg && i < total; i++) dclk_cycle(cfg_bits[i][0], q);
      if (full) begin
         for (int i = 0; i < r; i++) begin
            dclk_cycle(1'($urandom_range(0, 1)), q);
            expb = (i < exp_bits.size()) ? exp_bits[i] : 0;
            check_val($sformatf("dout_bit%0d", i), {31'd0, q}, expb);
            if (i == 0) begin
               check_val("dout_oe_active", {31'd0, dout_oe}, 1);
               if (scramble) scramble_ch();
            end
         end
      end
      wait_clk(half_per);
      cs_n = 1'b1;
      wait_clk(SYNC + 4);

      if (done_exp) begin
         last_sgl  = sgl;
         last_ch   = ch;
         last_code = code;
      end else if (exp_abort < 255) begin
         exp_abort++;
      end
      check_val("frame_done_cnt", done_cnt - done0, done_exp ? 1 : 0);
      check_val("dout_oe_idle", {31'd0, dout_oe}, 0);
      check_val("frame_sgl", {31'd0, frame_sgl}, last_sgl);
      check_val("frame_ch", {29'd0, frame_ch}, last_ch);
      check_val("frame_code", {22'd0, frame_code}, last_code);
      check_val("abort_cnt", {24'd0, abort_cnt}, exp_abort);
      $display("[TB] frame z=%0d sgl=%0d ch=%0d cfg=%0d/%0d resp=%0d half=%0d code=%03h %s",
               z, sgl, ch, ncfg, total, r, half_per, code, done_exp ? "done" : "abort");
   endtask

   initial begin
      logic q;
      int   d0;
      int   tot;

      rst_n = 1'b0;
      cs_n  = 1'b1;
      dclk  = 1'b0;
      din   = 1'b0;
      half_per  = 4;
      exp_abort = 0;
      last_sgl  = 0;
      last_ch   = 0;
      last_code = 0;
      scramble_ch();

      // reset state
      wait_clk(3);
      check_val("rst_dout", {31'd0, dout}, 0);
      check_val("rst_dout_oe", {31'd0, dout_oe}, 0);
      check_val("rst_frame_done", {31'd0, frame_done}, 0);
      check_val("rst_frame_sgl", {31'd0, frame_sgl}, 0);
      check_val("rst_frame_ch", {29'd0, frame_ch}, 0);
      check_val("rst_frame_code", {22'd0, frame_code}, 0);
      check_val("rst_abort_cnt", {24'd0, abort_cnt}, 0);
      rst_n = 1'b1;
      wait_clk(SYNC + 3);

      // single-ended read of CH2
      ch_m[2] = 'h2A5;
      apply_ch();
      run_frame(0, 1, 2, 5, 11, 1'b0);
      check_val("se_code_2a5", {22'd0, frame_code}, 'h2A5);

      // leading zeros, full LSB tail, trailing zeros
      ch_m[7] = 'h301;
      apply_ch();
      run_frame(3, 1, 7, 8, 24, 1'b0);

      // differential reads
      ch_m[4] = 'h200;
      ch_m[5] = 'h050;
      apply_ch();
      run_frame(0, 0, 4, 5, 11, 1'b0);
      check_val("diff_code_1b0", {22'd0, frame_code}, 'h1B0);
      run_frame(0, 0, 5, 5, 11, 1'b0);
      check_val("diff_code_neg", {22'd0, frame_code}, 0);

      // abort after D1, then a normal frame
      run_frame(0, 1, 3, 4, 0, 1'b0);
      check_val("abort_one", {24'd0, abort_cnt}, 1);
      run_frame(1, 1, 6, 6, 12, 1'b0);

      // randomized completed frames, with ch_data changed mid-frame
      for (int k = 0; k < 24; k++) begin
         half_per = $urandom_range(4, 8);
         tot = $urandom_range(0, 3);
         run_frame(tot, $urandom_range(0, 1), $urandom_range(0, 7), tot + 5,
                   $urandom_range(10, 26), 1'($urandom_range(0, 1)));
      end

      // randomized aborts until the counter saturates
      half_per = 4;
      for (int k = 0; k < 258; k++) begin
         tot = $urandom_range(0, 2);
         if ($urandom_range(0, 1) != 0)
            run_frame(tot, $urandom_range(0, 1), $urandom_range(0, 7),
                      $urandom_range(0, tot + 4), 0, 1'b0);
         else
            run_frame(tot, $urandom_range(0, 1), $urandom_range(0, 7), tot + 5,
                      $urandom_range(0, 9), 1'b0);
      end
      check_val("abort_sat", {24'd0, abort_cnt}, 255);

      // reset in the middle of MSB with cs_n held low
      d0 = done_cnt;
      cs_n = 1'b0;
      wait_clk(half_per);
      dclk_cycle(1'b1, q);
      dclk_cycle(1'b1, q);
      dclk_cycle(1'b1, q);
      dclk_cycle(1'b1, q);
      dclk_cycle(1'b0, q);
      for (int i = 0; i < 5; i++) dclk_cycle(1'b0, q);
      rst_n = 1'b0;
      wait_clk(3);
      rst_n = 1'b1;
      exp_abort = 0;
      last_sgl  = 0;
      last_ch   = 0;
      last_code = 0;
      wait_clk(2);
      check_val("mrst_dout_oe", {31'd0, dout_oe}, 0);
      check_val("mrst_abort", {24'd0, abort_cnt}, 0);
      check_val("mrst_code", {22'd0, frame_code}, 0);
      // a would-be frame while cs_n was never seen high must be ignored
      for (int i = 0; i < 16; i++) begin
         dclk_cycle((i == 0 || i == 1) ? 1'b1 : 1'b0, q);
         if (i == 15) check_val("mrst_no_drive", {31'd0, dout_oe}, 0);
      end
      wait_clk(half_per);
      cs_n = 1'b1;
      wait_clk(SYNC + 4);
      check_val("mrst_abort_after", {24'd0, abort_cnt}, 0);
      check_val("mrst_no_done", done_cnt - d0, 0);
      $display("[TB] reset mid-frame with cs_n low");
      run_frame(0, 1, 5, 5, 12, 1'b0);

      // back-to-back frames at 8:1 clk:dclk
      half_per = 4;
      d0 = done_cnt;
      run_frame(0, 1, 0, 5, 11, 1'b0);
      run_frame(0, 1, 1, 5, 11, 1'b0);
      run_frame(0, 1, 2, 5, 11, 1'b0);
      check_val("b2b_done_cnt", done_cnt - d0, 3);

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
